// File: rtl/urv_divider_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// urv_divider_ctrl_pkg
//   Shared definitions for the RV32M iterative divider:
//     - FUNC_* : x_fun_i encodings for DIV/DIVU/REM/REMU
//     - RD_SOURCE_DIVIDE : writeback source select that decode uses for divide ops
//     - div_state_t : sequencer state encodings (DIV_ST_*)
//     - helpers classifying a function code as signed / remainder
// -----------------------------------------------------------------------------
package urv_divider_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    localparam logic [2:0] RD_SOURCE_DIVIDE = 3'd4;

    typedef enum logic [2:0] {
        DIV_ST_IDLE = 3'd0,
        DIV_ST_PREP = 3'd1,
        DIV_ST_ITER = 3'd2,
        DIV_ST_FIX  = 3'd3,
        DIV_ST_DONE = 3'd4
    } div_state_t;

    function automatic logic is_signed_op(input logic [2:0] fun);
        return (fun == FUNC_DIV) || (fun == FUNC_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] fun);
        return (fun == FUNC_REM) || (fun == FUNC_REMU);
    endfunction

endpackage

// File: rtl/urv_div_step.sv
// -----------------------------------------------------------------------------
// urv_div_step
//   Combinational restoring shift-subtract step retiring BITS quotient bits.
//   The dividend is held in the quotient register and shifted out MSB-first
//   into the partial remainder while quotient bits shift in at the LSB.
// Ports:
//   rem_i     in  32  partial remainder (always < divisor, or any value if divisor 0)
//   quot_i    in  32  remaining dividend bits / quotient bits so far
//   divisor_i in  32  divisor magnitude
//   rem_o     out 32  next partial remainder
//   quot_o    out 32  next dividend/quotient register
// -----------------------------------------------------------------------------
module urv_div_step
    import urv_divider_ctrl_pkg::*;
#(
    parameter int BITS = 1
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quot_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quot_o
);

    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] q;
    logic [DATA_W:0]   trial;

    always_comb begin
        r     = rem_i;
        q     = quot_i;
        trial = '0;
        for (int b = 0; b < BITS; b++) begin
            // 33-bit trial value: remainder shifted left with next dividend bit
            trial = {r, q[DATA_W-1]};
            q     = {q[DATA_W-2:0], 1'b0};
            if (trial >= {1'b0, divisor_i}) begin
                trial = trial - {1'b0, divisor_i};
                q[0]  = 1'b1;
            end
            // After a subtract trial < divisor; without one trial < divisor as
            // well, so the top bit is always zero here.
            r = trial[DATA_W-1:0];
        end
        rem_o  = r;
        quot_o = q;
    end

endmodule

// File: rtl/urv_divider_ctrl.sv
// -----------------------------------------------------------------------------
// urv_divider_ctrl
//   Sequencer and datapath for iterative RV32M DIV/DIVU/REM/REMU in the execute
//   stage. Accepts one op from X, requests a stall while iterating, and returns
//   a registered 32-bit result for writeback.
//
//   Optional feature macro: URV_DIV_EARLY_OUT_EN
//     defined   - divide by zero skips the iterations (done 3 cycles after accept)
//     undefined - constant latency for every op
//
// Ports:
//   clk_i          in   1   clock
//   rst_n_i        in   1   asynchronous reset, active low
//   x_start_i      in   1   X holds a valid divide op (level, held while stalled)
//   x_stall_i      in   1   pipeline held by another source
//   x_kill_i       in   1   flush X; aborts any operation in progress
//   x_fun_i        in   3   100 DIV, 101 DIVU, 110 REM, 111 REMU
//   x_rs1_i        in   32  dividend
//   x_rs2_i        in   32  divisor
//   x_stall_req_o  out  1   stall request (combinational)
//   x_done_o       out  1   result valid for writeback
//   x_result_o     out  32  quotient or remainder
// -----------------------------------------------------------------------------
module urv_divider_ctrl
    import urv_divider_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              x_start_i,
    input  logic              x_stall_i,
    input  logic              x_kill_i,
    input  logic [2:0]        x_fun_i,
    input  logic [DATA_W-1:0] x_rs1_i,
    input  logic [DATA_W-1:0] x_rs2_i,
    output logic              x_stall_req_o,
    output logic              x_done_o,
    output logic [DATA_W-1:0] x_result_o
);

    localparam int         N_ITER    = DATA_W / BITS_PER_CYCLE;
    localparam logic [4:0] ITER_LAST = 5'(N_ITER - 1);

    div_state_t        state, state_nxt;
    logic [2:0]        fun_q;
    logic [DATA_W-1:0] rs1_q, rs2_q;
    logic [DATA_W-1:0] divisor_q, quot_q, rem_q, result_q;
    logic [4:0]        cnt_q;
    logic              q_neg_q, r_neg_q, dbz_q;
    logic [DATA_W-1:0] step_rem, step_quot;
    logic              accept;

    function automatic logic [DATA_W-1:0] neg_if(input logic cond,
                                                 input logic [DATA_W-1:0] v);
        return cond ? (~v + 1'b1) : v;
    endfunction

    assign accept        = (state == DIV_ST_IDLE) && x_start_i && !x_kill_i;
    assign x_stall_req_o = x_start_i && (state != DIV_ST_DONE) && !x_kill_i;
    assign x_done_o      = (state == DIV_ST_DONE);
    assign x_result_o    = result_q;

    urv_div_step #(
        .BITS      (BITS_PER_CYCLE)
    ) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= DIV_ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (x_kill_i) begin
            state_nxt = DIV_ST_IDLE;
        end else begin
            case (state)
                DIV_ST_IDLE: if (x_start_i) state_nxt = DIV_ST_PREP;
`ifdef URV_DIV_EARLY_OUT_EN
                DIV_ST_PREP: state_nxt = (rs2_q == '0) ? DIV_ST_FIX : DIV_ST_ITER;
`else
                DIV_ST_PREP: state_nxt = DIV_ST_ITER;
`endif
                DIV_ST_ITER: if (cnt_q == '0) state_nxt = DIV_ST_FIX;
                DIV_ST_FIX:  state_nxt = DIV_ST_DONE;
                // Holding in DONE while stalled keeps the still-present op
                // from being accepted a second time.
                DIV_ST_DONE: if (!x_stall_i) state_nxt = DIV_ST_IDLE;
                default:     state_nxt = DIV_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fun_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                DIV_ST_IDLE: begin
                    if (accept) begin
                        fun_q <= x_fun_i;
                        rs1_q <= x_rs1_i;
                        rs2_q <= x_rs2_i;
                    end
                end
                DIV_ST_PREP: begin
                    // Unsigned core works on magnitudes; signs are reapplied in FIX.
                    q_neg_q   <= is_signed_op(fun_q) && (rs1_q[DATA_W-1] ^ rs2_q[DATA_W-1]);
                    r_neg_q   <= is_signed_op(fun_q) && rs1_q[DATA_W-1];
                    quot_q    <= neg_if(is_signed_op(fun_q) && rs1_q[DATA_W-1], rs1_q);
                    divisor_q <= neg_if(is_signed_op(fun_q) && rs2_q[DATA_W-1], rs2_q);
                    rem_q     <= '0;
                    cnt_q     <= ITER_LAST;
                    dbz_q     <= (rs2_q == '0);
                end
                DIV_ST_ITER: begin
                    rem_q  <= step_rem;
                    quot_q <= step_quot;
                    if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
                end
                DIV_ST_FIX: begin
                    // Zero divisor takes the architectural result directly; the
                    // core's values may be partial when iterations were skipped.
                    if (!x_kill_i) begin
                        if (dbz_q)
                            result_q <= is_rem_op(fun_q) ? rs1_q : '1;
                        else if (is_rem_op(fun_q))
                            result_q <= neg_if(r_neg_q, rem_q);
                        else
                            result_q <= neg_if(q_neg_q, quot_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
